// File: rtl/matrix_pkg.sv
// Shared types and defaults for the result transmit path.
// RESULT_CHECKSUM_EN adds the CSUM state used for the trailing XOR byte.
package matrix_pkg;

    localparam int MAX_N_DEFAULT = 8;
    localparam int RES_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        ACK,
        DRAIN,
`ifdef RESULT_CHECKSUM_EN
        CSUM,
`endif
        DONE
    } tx_state_t;

    // Bytes carried by one result element (RES_W must be a multiple of 8).
    function automatic int bytes_per_elem(input int res_w);
        return res_w / 8;
    endfunction

endpackage

// File: rtl/result_sender_if.sv
// Result-buffer read port and UART TX byte handshake seen by result_sender.
interface result_sender_if
    import matrix_pkg::*;
#(
    parameter int AW    = 6,
    parameter int RES_W = RES_W_DEFAULT
);
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [RES_W-1:0] rd_data;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             tx_busy;

    modport master (
        output rd_en, rd_addr, tx_start, tx_data,
        input  rd_data, tx_busy
    );

    modport slave (
        input  rd_en, rd_addr, tx_start, tx_data,
        output rd_data, tx_busy
    );
endinterface

// File: rtl/result_sender.sv
// Reads the NxN result matrix row-major and streams it MSB byte first to the UART.
// Define RESULT_CHECKSUM_EN to append an XOR checksum byte to every valid frame.
module result_sender
    import matrix_pkg::*;
#(
    parameter int MAX_N = MAX_N_DEFAULT,
    parameter int RES_W = RES_W_DEFAULT,
    parameter int AW    = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [3:0]             matrix_size,
    result_sender_if.master        bus,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int NB = bytes_per_elem(RES_W);
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    tx_state_t        state;
    logic [AW:0]      elem_idx;
    logic [AW:0]      n_sq;
    logic [BW-1:0]    byte_idx;
    logic [RES_W-1:0] shreg;
    logic             in_csum;
`ifdef RESULT_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    logic [AW:0]      size_ext;
    logic [AW:0]      next_elem;
    logic             last_byte;
    logic             size_bad;
    logic [RES_W-1:0] launch_src;
    logic [7:0]       launch_byte;
    logic             launch;

    always_comb begin
        size_ext    = (AW+1)'(matrix_size);
        next_elem   = elem_idx + (AW+1)'(1);
        last_byte   = (byte_idx == BW'(NB - 1));
        size_bad    = (matrix_size == 4'd0) || (32'(matrix_size) > MAX_N);
        launch_src  = (state == LOAD) ? bus.rd_data : shreg;
        launch_byte = launch_src[RES_W-1 -: 8];
        launch      = 1'b0;
        if (!bus.tx_busy) begin
            unique case (state)
                LOAD, SEND: launch = 1'b1;
                DRAIN:      launch = !in_csum && !last_byte;
                default:    launch = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            elem_idx     <= '0;
            n_sq         <= '0;
            byte_idx     <= '0;
            shreg        <= '0;
            in_csum      <= 1'b0;
            bus.rd_en    <= 1'b0;
            bus.rd_addr  <= '0;
            bus.tx_start <= 1'b0;
            bus.tx_data  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            bus.tx_start <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (size_bad) begin
                            done  <= 1'b1;
                            err   <= (matrix_size != 4'd0);
                            state <= DONE;
                        end else begin
                            n_sq        <= size_ext * size_ext;
                            elem_idx    <= '0;
                            byte_idx    <= '0;
                            in_csum     <= 1'b0;
                            bus.rd_en   <= 1'b1;
                            bus.rd_addr <= '0;
                            busy        <= 1'b1;
                            state       <= FETCH;
`ifdef RESULT_CHECKSUM_EN
                            csum        <= '0;
`endif
                        end
                    end
                end

                FETCH: begin
                    bus.rd_en <= 1'b0;
                    state     <= LOAD;
                end

                LOAD: begin
                    shreg <= bus.rd_data;
                    state <= SEND;
                end

                SEND: state <= SEND;

                ACK: if (bus.tx_busy) state <= DRAIN;

                DRAIN: begin
                    if (!bus.tx_busy) begin
                        if (in_csum) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else if (!last_byte) begin
                            byte_idx <= byte_idx + BW'(1);
                            state    <= SEND;
                        end else begin
                            byte_idx <= '0;
                            elem_idx <= next_elem;
                            if (next_elem == n_sq) begin
`ifdef RESULT_CHECKSUM_EN
                                state <= CSUM;
`else
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= DONE;
`endif
                            end else begin
                                bus.rd_en   <= 1'b1;
                                bus.rd_addr <= next_elem[AW-1:0];
                                state       <= FETCH;
                            end
                        end
                    end
                end

`ifdef RESULT_CHECKSUM_EN
                CSUM: begin
                    shreg   <= RES_W'(csum) << (RES_W - 8);
                    in_csum <= 1'b1;
                    state   <= SEND;
                end
`endif

                DONE: state <= IDLE;

                default: state <= IDLE;
            endcase

            // A byte launches straight out of LOAD/SEND/DRAIN when the UART is idle,
            // overriding the case's next state so SEND only costs a cycle on a stall.
            if (launch) begin
                bus.tx_start <= 1'b1;
                bus.tx_data  <= launch_byte;
                shreg        <= launch_src << 8;
                state        <= ACK;
`ifdef RESULT_CHECKSUM_EN
                csum         <= csum ^ launch_byte;
`endif
            end
        end
    end

endmodule

// File: doc/result_sender.md
# result_sender

Transmit-side sequencer for the matrix-multiplication accelerator. After the multiplier finishes, this block reads the result matrix from the result buffer in row-major order and serializes each element into bytes. It drives those bytes to the UART transmitter through the `tx_start`/`tx_busy` handshake. It sits between the result buffer and the UART TX, and it is the outbound counterpart of the receive/control path that loads the size, A and B.

## Interface
- `MAX_N`, default 8: largest supported matrix dimension.
- `RES_W`, default 16: result element width in bits. Must be a multiple of 8.
- `AW`, default 6: result buffer address width. Must satisfy `2**AW >= MAX_N*MAX_N`.
- `clk` input 1: system clock. All logic is on the rising edge.
- `rst_n` input 1: **asynchronous, active-low reset.**
- `start` input 1: one-cycle pulse requesting transmission of the result matrix.
- `matrix_size` input 4: dimension N. Sampled on the cycle `start` is accepted.
- `rd_en` output 1: result buffer read strobe.
- `rd_addr` output AW: result buffer address, row-major (`row*N+col`).
- `rd_data` input RES_W: buffer read data, valid the cycle after `rd_en`.
- `tx_busy` input 1: UART TX is serializing a byte.
- `tx_start` output 1: one-cycle pulse that launches `tx_data`.
- `tx_data` output 8: byte to transmit. Held stable from `tx_start` until `tx_busy` falls.
- `busy` output 1: a frame is in progress.
- `done` output 1: one-cycle pulse when the frame completes.
- `err` output 1: one-cycle pulse, together with `done`, when the frame was rejected because of its size.

## Operation
- **States:**
  - IDLE → FETCH on `start`.
  - FETCH (`rd_en=1`) → LOAD.
  - LOAD latches `rd_data` into the shift register → SEND.
  - SEND waits for `!tx_busy`, then pulses `tx_start` → ACK.
  - ACK waits for `tx_busy`=1 → DRAIN.
  - DRAIN waits for `tx_busy`=0, then goes to SEND (next byte), FETCH (next element), CSUM or DONE.
  - CSUM sends the checksum via SEND/ACK/DRAIN.
  - DONE pulses `done` → IDLE.
- **Byte order:** each element is sent MSB byte first, `RES_W/8` bytes per element. Elements are sent from index 0 to N*N−1.
- **Counters:**
  - Element index is AW+1 bits wide. Comparing against N*N is done at that width, with no truncation.
  - Byte index is `$clog2(RES_W/8)` bits wide (minimum 1).
- **N = 0:** no reads and no bytes are sent. `done` pulses 1 cycle after `start`, with `err=0`.
- **N > MAX_N:** no reads and no bytes are sent. `done` and `err` pulse together 1 cycle after `start`.
- **`start` while `busy`=1:** ignored. `matrix_size` is not re-sampled.
- **`tx_busy` already high in SEND:** the block stalls with no `tx_start` until it drops.
- **Reset asserted mid-frame:** the frame is abandoned immediately. No resume, and no partial checksum is sent.
- **Reset values:** all outputs are 0, including `tx_start`, `rd_en`, `busy`, `done`, `err`, `tx_data` and `rd_addr`. State is IDLE and all counters are 0.

## Timing
- `start` is sampled at edge 0.
- `rd_en`/`rd_addr` are asserted in cycle 1.
- `rd_data` is captured in cycle 2.
- The earliest `tx_start` is in cycle 3, provided `tx_busy` is low.
- `busy` rises the cycle after `start` is accepted. It falls in the same cycle that `done` pulses.
- `tx_start` is never asserted in two consecutive cycles. It is never asserted while `tx_busy`=1.
- Per-byte overhead beyond the UART byte time: 2 cycles (ACK detect plus DRAIN exit). Each element adds 2 more cycles (FETCH, LOAD).
- `done` pulses the cycle after the final DRAIN sees `tx_busy`=0.

## Configuration
- **`RESULT_CHECKSUM_EN` defined:**
  - The block keeps a running 8-bit XOR of every transmitted data byte.
  - After the last element, CSUM sends one extra byte carrying that XOR value.
  - The XOR accumulator clears on `start`.
- **`RESULT_CHECKSUM_EN` undefined:** the CSUM state and the accumulator are absent. The frame is exactly N*N*RES_W/8 bytes.
- For N=0 and for N>MAX_N, no checksum byte is sent in either configuration.

## Structure
- **`matrix_pkg`** holds:
  - the state enum `tx_state_t`;
  - the constants `MAX_N` and `RES_W` defaults;
  - the byte-count helper function.
- **Sub-module:** none. The single module `result_sender` contains the FSM, counters, shift register and checksum.

## Test plan
- **2×2, no macro.** Buffer holds 0x0102, 0x0304, 0x0506, 0x0708. Model the UART with 10 busy cycles per byte. Expect bytes 01 02 03 04 05 06 07 08, then `done`, with `err=0`.
- **Same 2×2 with `RESULT_CHECKSUM_EN`.** Expect 9 bytes, the last being 0x08.
- **`matrix_size`=0.** Expect `done` 1 cycle after `start`, no `rd_en`, no `tx_start`, `err=0`.
- **`matrix_size`=9 with `MAX_N`=8.** Expect `done` and `err` pulsing together, and zero bytes sent.
- **`tx_busy` held high for 50 cycles on entering SEND.** Expect no `tx_start` until the cycle after `tx_busy` falls. `tx_data` stays stable.
- **Reset and re-start.**
  - Assert `rst_n`=0 after the 3rd byte of a 3×3 frame. Expect all outputs to go to 0 asynchronously.
  - A `start` pulse issued while `busy`=1 is ignored.
  - A new `start` after reset sends from element 0.
